// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
//   fetch_state_e : sequencer states
//   fetch_entry_t : one buffered fetch result {pc, instr}
//   PcStep        : byte increment between sequential fetches
package fetch_pkg;

    localparam int unsigned FetchBits = 32;

    localparam logic [FetchBits-1:0] PcStep = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [FetchBits-1:0] pc;
        logic [FetchBits-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched instructions until decode takes them.
// The head entry is read straight from storage, so downstream sees registered data.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset (clears storage too)
//   push_i/data_i : write one entry; caller guarantees there is room
//   pop_i         : retire the head entry (ignored when empty)
//   flush_i       : drop all entries; wins over push and pop in the same cycle
//   head_o        : entry at the head
//   count_o       : number of valid entries (0..Depth)
//   full_o/empty_o: occupancy flags
module fetch_fifo #(
    parameter int unsigned Depth   = 2,
    parameter type         entry_t = logic [63:0]
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  entry_t                 data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output entry_t                 head_o,
    output logic [$clog2(Depth):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned PtrBits = $clog2(Depth);
    localparam int unsigned CntBits = PtrBits + 1;

    entry_t               r_mem [Depth];
    logic [PtrBits-1:0]   r_wr_ptr;
    logic [PtrBits-1:0]   r_rd_ptr;
    logic [CntBits-1:0]   r_count;
    logic                 w_do_pop;

    assign empty_o  = (r_count == '0);
    assign full_o   = (r_count == CntBits'(Depth));
    assign count_o  = r_count;
    assign head_o   = r_mem[r_rd_ptr];
    assign w_do_pop = pop_i & ~empty_o;

    // Depth is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) begin
                r_mem[r_wr_ptr] <= data_i;
                r_wr_ptr        <= r_wr_ptr + PtrBits'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrBits'(1);
            end
            r_count <= r_count + CntBits'(push_i) - CntBits'(w_do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues word-addressed reads to a memory
// with one-cycle registered read latency, buffers {pc, instr} in fetch_fifo and
// hands entries to decode over valid/ready. Redirects flush the buffer and kill
// any response still in flight.
// Ports:
//   clk_i, rst_i         : clock, synchronous active-high reset
//   fetch_en_i           : allow new memory requests
//   redirect_i/_pc_i     : branch/jump target (byte address, low bits ignored)
//   mem_req_o/mem_addr_o : read request and word address
//   mem_rdata_i          : read data, valid the cycle after a request
//   valid_o/ready_i      : handshake to decode
//   instr_o/pc_o         : FIFO head entry
//
// state | meaning
// IDLE  | no requests; waits for fetch_en_i
// RUN   | issues one request per cycle while credit is available
// HOLD  | credit exhausted; returns to RUN once a slot frees
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned         RegBits = FetchBits,
    parameter logic [RegBits-1:0]  ResetPc = '0,
    parameter int unsigned         Depth   = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               fetch_en_i,
    input  logic               redirect_i,
    input  logic [RegBits-1:0] redirect_pc_i,
    output logic               mem_req_o,
    output logic [RegBits-1:0] mem_addr_o,
    input  logic [RegBits-1:0] mem_rdata_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [RegBits-1:0] instr_o,
    output logic [RegBits-1:0] pc_o
);

    localparam int unsigned CntBits = $clog2(Depth) + 1;
    localparam int unsigned CrdBits = CntBits + 1;

    fetch_state_e         r_state;
    fetch_state_e         w_state_nxt;
    logic [RegBits-1:0]   r_pc;
    logic [RegBits-1:0]   r_req_pc;
    logic                 r_inflight;
    logic                 r_req_epoch;
    logic                 r_epoch;

    logic [CntBits-1:0]   w_count;
    logic                 w_full;
    logic                 w_empty;
    fetch_entry_t         w_head;
    fetch_entry_t         w_push_entry;
    logic                 w_valid;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_epoch_nxt;
    logic [CrdBits-1:0]   w_used;
    logic                 w_credit;

    // Redirect owns the cycle: nothing is presented, so nothing is consumed.
    assign w_valid = ~w_empty & ~redirect_i;
    assign w_pop   = w_valid & ready_i;

    // Slots already promised = stored entries + the response on its way back,
    // minus the one decode takes this cycle.
    assign w_used   = CrdBits'(w_count) + CrdBits'(r_inflight) - CrdBits'(w_pop);
    assign w_credit = (w_used < CrdBits'(Depth));

    // A response is kept only if its epoch matches the epoch after this edge,
    // so a redirect in the response cycle kills it.
    assign w_epoch_nxt = r_epoch ^ redirect_i;
    assign w_push      = r_inflight & (r_req_epoch == w_epoch_nxt) & (~w_full | w_pop);

    assign w_push_entry.pc    = r_req_pc;
    assign w_push_entry.instr = mem_rdata_i;

    fetch_fifo #(
        .Depth   (Depth),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .data_i  (w_push_entry),
        .pop_i   (w_pop),
        .flush_i (redirect_i),
        .head_o  (w_head),
        .count_o (w_count),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A redirect empties the buffer, so an active fetcher goes straight to RUN
    // and requests the target on the next cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (!fetch_en_i) begin
            w_state_nxt = IDLE;
        end else if (r_state == IDLE || redirect_i) begin
            w_state_nxt = RUN;
        end else begin
            case (r_state)
                RUN:     if (!w_credit) w_state_nxt = HOLD;
                HOLD:    if (w_credit)  w_state_nxt = RUN;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req_o = (r_state == RUN) & fetch_en_i & ~redirect_i & w_credit;
        valid_o   = w_valid;
    end

    assign mem_addr_o = {2'b00, r_pc[RegBits-1:2]};
    assign instr_o    = w_head.instr;
    assign pc_o       = w_head.pc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc        <= ResetPc;
            r_req_pc    <= '0;
            r_inflight  <= 1'b0;
            r_req_epoch <= 1'b0;
            r_epoch     <= 1'b0;
        end else begin
            r_epoch    <= w_epoch_nxt;
            r_inflight <= mem_req_o;
            if (mem_req_o) begin
                r_req_pc    <= r_pc;
                r_req_epoch <= w_epoch_nxt;
            end
            if (redirect_i) begin
                r_pc <= {redirect_pc_i[RegBits-1:2], 2'b00};
            end else if (mem_req_o) begin
                r_pc <= r_pc + RegBits'(PcStep);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a one-cycle registered memory model
// returning 0x1000 + word address.
module tb_instr_fetch_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        fetch_en_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_rdata_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    instr_fetch_ctrl #(
        .RegBits (32),
        .ResetPc (32'h0),
        .Depth   (2)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .fetch_en_i    (fetch_en_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_rdata_i   (mem_rdata_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o)
    );

    always_ff @(posedge clk_i) begin
        if (mem_req_o) mem_rdata_i <= 32'h1000 + mem_addr_o;
        else           mem_rdata_i <= 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    task automatic chk_req(input string tag, input logic exp_req, input logic [31:0] exp_addr);
        chk({tag, "_req"}, {31'b0, mem_req_o}, {31'b0, exp_req});
        if (exp_req) chk({tag, "_addr"}, mem_addr_o, exp_addr);
    endtask

    task automatic chk_out(input string tag, input logic exp_valid,
                           input logic [31:0] exp_pc, input logic [31:0] exp_instr);
        chk({tag, "_valid"}, {31'b0, valid_o}, {31'b0, exp_valid});
        if (exp_valid) begin
            chk({tag, "_pc"}, pc_o, exp_pc);
            chk({tag, "_instr"}, instr_o, exp_instr);
        end
    endtask

    // Waits (bounded) for the next accepted entry and checks it.
    task automatic wait_pop(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_instr);
        bit seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            smp();
            if (valid_o && ready_i) begin
                seen = 1'b1;
                chk({tag, "_pc"}, pc_o, exp_pc);
                chk({tag, "_instr"}, instr_o, exp_instr);
            end
            next_cyc();
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s: observed=no accepted entry in 4 cycles expected pc=%h", tag, exp_pc);
        end
    endtask

    logic [31:0] wrap_pc    [4];
    logic [31:0] wrap_instr [4];

    initial begin
        wrap_pc    = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        wrap_instr = '{32'h4000_0FFE, 32'h4000_0FFF, 32'h0000_1000, 32'h0000_1001};

        rst_i = 1'b1; fetch_en_i = 1'b0; ready_i = 1'b0;
        redirect_i = 1'b0; redirect_pc_i = 32'h0;
        next_cyc();
        next_cyc();
        smp();
        chk_req("rst", 1'b0, 32'h0);
        chk("rst_valid", {31'b0, valid_o}, 32'h0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        next_cyc();

        // Sequential fetch
        rst_i = 1'b0; fetch_en_i = 1'b1; ready_i = 1'b1;
        smp(); chk_req("c0", 1'b0, 32'h0); chk_out("c0", 1'b0, 32'h0, 32'h0); next_cyc();
        smp(); chk_req("c1", 1'b1, 32'h0); chk_out("c1", 1'b0, 32'h0, 32'h0); next_cyc();
        smp(); chk_req("c2", 1'b1, 32'h1); chk_out("c2", 1'b0, 32'h0, 32'h0); next_cyc();
        for (int k = 0; k < 6; k++) begin
            smp();
            chk_out("seq", 1'b1, 32'(4 * k), 32'h1000 + 32'(k));
            chk_req("seq", 1'b1, 32'(k + 2));
            next_cyc();
        end

        // Backpressure: five cycles with ready low, head must hold at pc 24
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            smp();
            chk_req("bp", 1'b0, 32'h0);
            chk_out("bp", 1'b1, 32'd24, 32'h1006);
            next_cyc();
        end
        ready_i = 1'b1;
        for (int j = 0; j < 5; j++) begin
            wait_pop("resume", 32'(24 + 4 * j), 32'h1006 + 32'(j));
        end
        next_cyc();
        next_cyc();

        // Redirect together with a pop
        redirect_i = 1'b1; redirect_pc_i = 32'h100;
        smp(); chk_req("rdp_n", 1'b0, 32'h0); chk_out("rdp_n", 1'b0, 32'h0, 32'h0); next_cyc();
        redirect_i = 1'b0;
        smp(); chk_req("rdp_n1", 1'b1, 32'h40); chk_out("rdp_n1", 1'b0, 32'h0, 32'h0); next_cyc();
        smp(); chk_req("rdp_n2", 1'b1, 32'h41); chk_out("rdp_n2", 1'b0, 32'h0, 32'h0); next_cyc();
        smp(); chk_req("rdp_n3", 1'b1, 32'h42); chk_out("rdp_n3", 1'b1, 32'h100, 32'h1040); next_cyc();

        // Build up: buffered entry plus a response in flight, then redirect
        ready_i = 1'b0;
        smp(); chk_req("hold", 1'b0, 32'h0); chk_out("hold", 1'b1, 32'h104, 32'h1041); next_cyc();
        ready_i = 1'b1;
        smp(); chk_out("rel", 1'b1, 32'h104, 32'h1041); next_cyc();
        ready_i = 1'b0;
        smp(); chk_req("infl", 1'b1, 32'h43); chk_out("infl", 1'b1, 32'h108, 32'h1042); next_cyc();
        redirect_i = 1'b1; redirect_pc_i = 32'h43;
        smp(); chk_req("rdk_n", 1'b0, 32'h0); chk_out("rdk_n", 1'b0, 32'h0, 32'h0); next_cyc();
        redirect_i = 1'b0; ready_i = 1'b1;
        smp(); chk_req("rdk_n1", 1'b1, 32'h10); chk_out("rdk_n1", 1'b0, 32'h0, 32'h0); next_cyc();
        smp(); chk_req("rdk_n2", 1'b1, 32'h11); chk_out("rdk_n2", 1'b0, 32'h0, 32'h0); next_cyc();
        smp(); chk_req("rdk_n3", 1'b1, 32'h12); chk_out("rdk_n3", 1'b1, 32'h40, 32'h1010); next_cyc();
        smp(); chk_out("rdk_n4", 1'b1, 32'h44, 32'h1011); next_cyc();

        // Wrap-around
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
        smp(); chk_req("wr_n", 1'b0, 32'h0); chk_out("wr_n", 1'b0, 32'h0, 32'h0); next_cyc();
        redirect_i = 1'b0;
        smp(); chk_req("wr_n1", 1'b1, 32'h3FFF_FFFE); chk_out("wr_n1", 1'b0, 32'h0, 32'h0); next_cyc();
        smp(); chk_req("wr_n2", 1'b1, 32'h3FFF_FFFF); chk_out("wr_n2", 1'b0, 32'h0, 32'h0); next_cyc();
        for (int k = 0; k < 4; k++) begin
            smp();
            chk_out("wrap", 1'b1, wrap_pc[k], wrap_instr[k]);
            chk_req("wrap", 1'b1, 32'(k));
            next_cyc();
        end

        // fetch_en drop with a response in flight, then resets
        fetch_en_i = 1'b0;
        smp(); chk_req("den", 1'b0, 32'h0); chk_out("den", 1'b1, 32'h8, 32'h1002); next_cyc();
        ready_i = 1'b0;
        smp(); chk_req("den1", 1'b0, 32'h0); chk_out("den1", 1'b1, 32'hC, 32'h1003); next_cyc();
        rst_i = 1'b1;
        smp(); chk_req("rst2", 1'b0, 32'h0); next_cyc();
        rst_i = 1'b0; fetch_en_i = 1'b1; ready_i = 1'b1;
        smp();
        chk_req("post_rst", 1'b0, 32'h0);
        chk("post_rst_valid", {31'b0, valid_o}, 32'h0);
        chk("post_rst_instr", instr_o, 32'h0);
        chk("post_rst_pc", pc_o, 32'h0);
        next_cyc();
        rst_i = 1'b1;
        smp(); chk_req("rst_mid", 1'b1, 32'h0); next_cyc();
        rst_i = 1'b0;
        smp(); chk_req("drop_c0", 1'b0, 32'h0); chk_out("drop_c0", 1'b0, 32'h0, 32'h0); next_cyc();
        smp(); chk_req("drop_c1", 1'b1, 32'h0); chk_out("drop_c1", 1'b0, 32'h0, 32'h0); next_cyc();
        smp(); chk_req("drop_c2", 1'b1, 32'h1); chk_out("drop_c2", 1'b0, 32'h0, 32'h0); next_cyc();
        smp(); chk_out("drop_c3", 1'b1, 32'h0, 32'h1000); next_cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
